// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame FSM states and PS/2 prefix byte constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchroniser plus stability filter for one raw PS/2 line
// Ports: clk_50m system clock, rst_n async active-low reset, raw asynchronous line in,
//        filt filtered line (resets to 1, follows raw after FILTER_LEN stable samples)
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // cnt counts consecutive synchronised samples that disagree with filt
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 device-to-host receiver folding F0/E0 prefixes into flags
// Ports: clk_50m system clock, rst_n async active-low reset, kclk/kdata raw PS/2 lines,
//        code last scancode, is_break/is_ext prefix flags held with code,
//        code_valid one-cycle new-code strobe, frame_err one-cycle parity/stop/timeout strobe
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_ext,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  logic          kclk_f, kdata_f, kclk_d, fall;
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          good, bad, brk_pend, ext_pend;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_50m(clk_50m), .rst_n(rst_n), .raw(kclk), .filt(kclk_f)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_50m(clk_50m), .rst_n(rst_n), .raw(kdata), .filt(kdata_f)
  );

  assign fall = kclk_d & ~kclk_f;

  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      kclk_d  <= 1'b1;
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      kclk_d  <= kclk_f;
      state   <= state_n;
      bit_cnt <= bit_n;
      sh      <= sh_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
    end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = sh;
    par_n   = par;
    good    = 1'b0;
    bad     = 1'b0;
    // saturating gap counter; idles at zero outside a frame
    tcnt_n  = (state == IDLE || fall) ? '0 : (tcnt == TMAX ? tcnt : tcnt + 1'b1);
    case (state)
      IDLE:
        if (fall && !kdata_f) begin
          state_n = DATA;
          bit_n   = '0;
        end
      DATA:
        if (fall) begin
          sh_n    = {kdata_f, sh[7:1]};
          bit_n   = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        end
      PARITY:
        if (fall) begin
          par_n   = kdata_f;
          state_n = STOP;
        end
      default:
        if (fall) begin
          state_n = IDLE;
          good    = kdata_f & ^{sh, par};
          bad     = ~good;
        end
    endcase
    // a fall in the same cycle keeps the frame alive
    if (state != IDLE && !fall && tcnt == TMAX) begin
      state_n = IDLE;
      bad     = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      code       <= '0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      code_valid <= good && sh != PS2_BREAK && sh != PS2_EXT;
      frame_err  <= bad;
      if (bad) begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else if (good) begin
        if (sh == PS2_BREAK) brk_pend <= 1'b1;
        else if (sh == PS2_EXT) ext_pend <= 1'b1;
        else begin
          code     <= sh;
          is_break <= brk_pend;
          is_ext   <= ext_pend;
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven, hand-written and randomized checks of ps2_scancode_rx
module tb_ps2_scancode_rx;
  localparam int TO = 2000;
  logic clk = 1'b0, rst_n = 1'b0, kclk = 1'b1, kdata = 1'b1;
  logic [7:0] code;
  logic is_break, is_ext, code_valid, frame_err;
  int checks = 0, errors = 0, nv = 0, ne = 0, nboth = 0;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk_50m(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata), .code(code),
    .is_break(is_break), .is_ext(is_ext), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) nv++;
    if (frame_err) ne++;
    if (code_valid && frame_err) nboth++;
  end

  typedef struct {
    logic [7:0] b;
    bit bp, bs, v;
    logic [7:0] c;
    bit br, ex, er;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kdata = bits[i];
      repeat (20) @(posedge clk);
      kclk = 1'b0;
      repeat (40) @(posedge clk);
      kclk = 1'b1;
      repeat (20) @(posedge clk);
    end
    kdata = 1'b1;
    repeat (40) @(posedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input bit bp, input bit bs, input int n,
                       output int dv, output int de);
    int v0, e0;
    logic p;
    v0 = nv;
    e0 = ne;
    p = ~(^b) ^ bp;
    send_bits({~bs, p, b, 1'b0}, n);
    dv = nv - v0;
    de = ne - e0;
  endtask

  task automatic chk_out(input string nm, input int dv, input int de, input bit ev, input bit ee,
                         input logic [7:0] c, input bit br, input bit ex);
    chk({nm, " valid"}, dv, int'(ev));
    chk({nm, " err"}, de, int'(ee));
    chk({nm, " code"}, int'(code), int'(c));
    chk({nm, " brk"}, int'(is_break), int'(br));
    chk({nm, " ext"}, int'(is_ext), int'(ex));
  endtask

  // reference model: prefix flags and last code, from the protocol rules
  logic [7:0] m_code;
  bit m_brk, m_ext, m_isb, m_ise;

  initial begin
    int dv, de;
    logic [7:0] b;
    bit bp, bs, ev, ee;
    tbl[0]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 0};
    tbl[1]  = '{8'hF0, 0, 0, 0, 8'h1D, 0, 0, 0};
    tbl[2]  = '{8'h1D, 0, 0, 1, 8'h1D, 1, 0, 0};
    tbl[3]  = '{8'hE0, 0, 0, 0, 8'h1D, 1, 0, 0};
    tbl[4]  = '{8'hF0, 0, 0, 0, 8'h1D, 1, 0, 0};
    tbl[5]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0};
    tbl[6]  = '{8'h29, 0, 0, 1, 8'h29, 0, 0, 0};
    tbl[7]  = '{8'h1D, 1, 0, 0, 8'h29, 0, 0, 1};
    tbl[8]  = '{8'h1D, 0, 1, 0, 8'h29, 0, 0, 1};
    tbl[9]  = '{8'hF0, 0, 0, 0, 8'h29, 0, 0, 0};
    tbl[10] = '{8'h1D, 1, 0, 0, 8'h29, 0, 0, 1};
    tbl[11] = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset code", int'(code), 0);
    chk("reset flags", int'({is_break, is_ext, code_valid, frame_err}), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      frame(tbl[i].b, tbl[i].bp, tbl[i].bs, 11, dv, de);
      chk_out($sformatf("tbl%0d", i), dv, de, tbl[i].v, tbl[i].er, tbl[i].c, tbl[i].br, tbl[i].ex);
    end

    // short kclk glitch with data low must not look like a start bit
    dv = nv;
    de = ne;
    kdata = 1'b0;
    kclk = 1'b0;
    repeat (6) @(posedge clk);
    kclk = 1'b1;
    repeat (30) @(posedge clk);
    kdata = 1'b1;
    repeat (30) @(posedge clk);
    chk("glitch strobes", nv - dv + ne - de, 0);
    frame(8'h5A, 0, 0, 11, dv, de);
    chk_out("after glitch", dv, de, 1, 0, 8'h5A, 0, 0);

    // F0 then abandoned frame: one timeout error, pending break dropped
    frame(8'hF0, 0, 0, 11, dv, de);
    frame(8'h33, 0, 0, 5, dv, de);
    chk("partial err early", de, 0);
    dv = nv;
    de = ne;
    repeat (TO + 200) @(posedge clk);
    chk("timeout err", ne - de, 1);
    chk("timeout valid", nv - dv, 0);
    frame(8'h1C, 0, 0, 11, dv, de);
    chk_out("after timeout", dv, de, 1, 0, 8'h1C, 0, 0);

    // reset in the middle of a data phase
    frame(8'hE0, 0, 0, 11, dv, de);
    frame(8'h6B, 0, 0, 4, dv, de);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset code", int'(code), 0);
    chk("midreset flags", int'({is_break, is_ext, code_valid, frame_err}), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    frame(8'h1D, 0, 0, 11, dv, de);
    chk_out("after reset", dv, de, 1, 0, 8'h1D, 0, 0);

    m_code = 8'h1D;
    m_isb = 0;
    m_ise = 0;
    m_brk = 0;
    m_ext = 0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0, 1: b = 8'hF0;
        2: b = 8'hE0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = $urandom_range(0, 7) == 0;
      bs = !bp && $urandom_range(0, 9) == 0;
      ev = 0;
      ee = bp || bs;
      if (ee) begin
        m_brk = 0;
        m_ext = 0;
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
        ev = 1;
        m_code = b;
        m_isb = m_brk;
        m_ise = m_ext;
        m_brk = 0;
        m_ext = 0;
      end
      frame(b, bp, bs, 11, dv, de);
      chk_out($sformatf("rnd%0d %02h", i, b), dv, de, ev, ee, m_code, m_isb, m_ise);
    end

    chk("valid and err together", nboth, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
